// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: state encoding, default frame width, check point.
// Combinational helpers only; no timing or flow-control behaviour of its own.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        ERR_CHK = 3'd5
    } state_t;

    localparam int DATA_WIDTH_DEF = 8;

    // Sample point sits two clocks past mid-bit, giving the sampler's majority vote time to settle.
    localparam logic [5:0] CHK_OFFSET = 6'd2;

    function automatic logic [5:0] chk_point(input logic [5:0] prescale);
        return (prescale >> 1) + CHK_OFFSET;
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: drives sampler/deserialiser/checker strobes and reports frame status.
// Strobes decode the current state in-cycle; data_valid/frame_err are registered, one cycle in ERR_CHK; no backpressure.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       PAR_EN,
    input  logic [5:0] prescale,
    input  logic [4:0] edge_cnt,
    input  logic [3:0] bit_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       edge_bit_enable,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       frame_err
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH);

    state_t     state;
    logic       par_en_q;
    logic       glitch_flag;
    logic       par_flag;
    logic       stp_flag;
    logic       strt_chk_q;
    logic       par_chk_q;
    logic       stp_chk_q;

    logic [5:0] edge_ext;
    logic [5:0] last_edge;
    logic       at_chk;
    logic       eob;
    logic       in_bit;
    logic       glitch_now;
    logic       err_now;
    logic       start_now;

    assign edge_ext  = {1'b0, edge_cnt};
    assign last_edge = prescale - 6'd1;
    assign at_chk    = (edge_ext == chk_point(prescale));

    // A last edge the 5-bit counter can never reach (prescale 0 or above 32) falls back to its top value.
    assign eob = (edge_ext == last_edge) || ((last_edge > 6'd31) && (edge_cnt == 5'd31));

    assign in_bit = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);

    assign edge_bit_enable = in_bit;
    assign dat_samp_en     = in_bit;
    assign strt_chk_en     = (state == START)  && at_chk;
    assign deser_en        = (state == DATA)   && at_chk;
    assign par_chk_en      = (state == PARITY) && at_chk;
    assign stp_chk_en      = (state == STOP)   && at_chk;

    // Checker results land one cycle after their enable; include the in-flight result so a late
    // stop check still counts when the bit ends on the very next edge.
    assign glitch_now = glitch_flag | (strt_chk_q & strt_glitch);
    assign err_now    = par_flag | stp_flag | (par_chk_q & par_err) | (stp_chk_q & stp_err);
    assign start_now  = ((state == IDLE) || (state == ERR_CHK)) && !rx_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            par_en_q    <= 1'b0;
            glitch_flag <= 1'b0;
            par_flag    <= 1'b0;
            stp_flag    <= 1'b0;
            strt_chk_q  <= 1'b0;
            par_chk_q   <= 1'b0;
            stp_chk_q   <= 1'b0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            strt_chk_q <= strt_chk_en;
            par_chk_q  <= par_chk_en;
            stp_chk_q  <= stp_chk_en;

            if (strt_chk_q && strt_glitch) glitch_flag <= 1'b1;
            if (par_chk_q && par_err)      par_flag    <= 1'b1;
            if (stp_chk_q && stp_err)      stp_flag    <= 1'b1;

            case (state)
                IDLE: begin
                    if (!rx_in) state <= START;
                end
                START: begin
                    if (eob) state <= glitch_now ? IDLE : DATA;
                end
                DATA: begin
                    if (eob && (bit_cnt >= LAST_BIT)) state <= par_en_q ? PARITY : STOP;
                end
                PARITY: begin
                    if (eob) state <= STOP;
                end
                STOP: begin
                    if (eob) begin
                        state      <= ERR_CHK;
                        data_valid <= !err_now;
                        frame_err  <= err_now;
                    end
                end
                ERR_CHK: begin
                    state <= rx_in ? IDLE : START;
                end
                default: state <= IDLE;
            endcase

            // New frame: take a fresh parity setting and forget the previous frame's verdicts.
            if (start_now) begin
                par_en_q    <= PAR_EN;
                glitch_flag <= 1'b0;
                par_flag    <= 1'b0;
                stp_flag    <= 1'b0;
                strt_chk_q  <= 1'b0;
                par_chk_q   <= 1'b0;
                stp_chk_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: behavioural counter/checker peers, frame-level reference model and scoreboard.
module tb_uart_rx_fsm;
    import uart_rx_pkg::*;

    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       PAR_EN = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       strt_glitch, par_err, stp_err;
    logic       edge_bit_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, frame_err;

    uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .PAR_EN(PAR_EN), .prescale(prescale),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_bit_enable(edge_bit_enable), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
        .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
        .data_valid(data_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Peer blocks: edge/bit counter and the start/parity/stop checkers answering one cycle after their enable.
    bit cfg_glitch = 0, cfg_perr = 0, cfg_serr = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0; bit_cnt <= '0;
            strt_glitch <= 1'b0; par_err <= 1'b0; stp_err <= 1'b0;
        end else begin
            if (!edge_bit_enable) begin
                edge_cnt <= '0; bit_cnt <= '0;
            end else if ({1'b0, edge_cnt} == prescale - 6'd1) begin
                edge_cnt <= '0; bit_cnt <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + 5'd1;
            end
            strt_glitch <= strt_chk_en & cfg_glitch;
            par_err     <= par_chk_en  & cfg_perr;
            stp_err     <= stp_chk_en  & cfg_serr;
        end
    end

    // Reference model: what a whole frame should produce, from frame length and error rules.
    typedef struct {
        int end_cyc;
        int kind;       // 0 nothing, 1 data_valid, 2 frame_err
        int n_deser;
        int n_par;
        int n_stp;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t predict(int t0, int ps, bit p, bit g, bit pe, bit se);
        exp_t e;
        int nbits;
        nbits     = g ? 1 : DW + 2 + int'(p);
        e.end_cyc = t0 + 1 + nbits * ps;
        e.kind    = g ? 0 : (((p && pe) || se) ? 2 : 1);
        e.n_deser = g ? 0 : DW;
        e.n_par   = (!g && p) ? 1 : 0;
        e.n_stp   = g ? 0 : 1;
        return e;
    endfunction

    // Monitor: counts strobes per frame, pops the scoreboard when the bit-enable drops.
    int n_strt = 0, n_deser = 0, n_par = 0, n_stp = 0;
    bit en_prev = 0;
    always @(negedge clk) begin
        exp_t e;
        int   chk_at;
        if (rst) begin
            n_strt = 0; n_deser = 0; n_par = 0; n_stp = 0; en_prev = 0;
        end else begin
            chk_at = int'(prescale) / 2 + 2;
            chk("dv_fe_both", int'(data_valid & frame_err), 0);
            if (strt_chk_en) begin n_strt++;  chk("strt_edge", int'(edge_cnt), chk_at); chk("samp_en", int'(dat_samp_en), 1); end
            if (deser_en)    begin n_deser++; chk("deser_edge", int'(edge_cnt), chk_at); chk("samp_en", int'(dat_samp_en), 1); end
            if (par_chk_en)  begin n_par++;   chk("par_edge", int'(edge_cnt), chk_at); end
            if (stp_chk_en)  begin n_stp++;   chk("stp_edge", int'(edge_cnt), chk_at); end
            if (en_prev && !edge_bit_enable) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame_end actual=end_seen expected=none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("end_cycle", cyc, e.end_cyc);
                    chk("data_valid", int'(data_valid), int'(e.kind == 1));
                    chk("frame_err", int'(frame_err), int'(e.kind == 2));
                    chk("n_strt_chk", n_strt, 1);
                    chk("n_deser", n_deser, e.n_deser);
                    chk("n_par_chk", n_par, e.n_par);
                    chk("n_stp_chk", n_stp, e.n_stp);
                end
                n_strt = 0; n_deser = 0; n_par = 0; n_stp = 0;
            end else begin
                chk("stray_pulse", int'(data_valid | frame_err), 0);
            end
            en_prev = edge_bit_enable;
        end
    end

    // Drives one frame starting at the current negedge; returns in ERR_CHK when b2b is set.
    task automatic send_frame(input int ps, input bit p, input bit g, input bit pe, input bit se,
                              input bit b2b, input bit tog, input logic [7:0] data);
        exp_t e;
        prescale   = 6'(ps);
        PAR_EN     = p;
        cfg_glitch = g; cfg_perr = pe; cfg_serr = se;
        rx_in      = 1'b0;
        e = predict(cyc, ps, p, g, pe, se);
        sb.push_back(e);
        if (g) begin
            repeat (2) @(negedge clk);
            rx_in = 1'b1;
        end else begin
            repeat (ps) @(negedge clk);
            for (int i = 0; i < DW; i++) begin
                rx_in = data[i];
                if (tog && i == DW / 2) PAR_EN = ~p;
                repeat (ps) @(negedge clk);
            end
            if (p) begin
                rx_in = (^data) ^ pe;
                repeat (ps) @(negedge clk);
            end
            rx_in = ~se;
        end
        while (cyc < e.end_cyc) @(negedge clk);
        if (!b2b) begin
            rx_in = 1'b1;
            @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic reset_mid_frame();
        int w = 0;
        prescale = 6'd16; PAR_EN = 1'b0;
        cfg_glitch = 0; cfg_perr = 0; cfg_serr = 0;
        rx_in = 1'b0;
        @(negedge clk);
        rx_in = 1'b1;
        while (bit_cnt != 4'd4 && w < 2000) begin @(negedge clk); w++; end
        chk("rst_reach_bit4", int'(bit_cnt), 4);
        #2 rst = 1'b1;
        #1 chk("rst_outputs", int'({edge_bit_enable, dat_samp_en, deser_en, strt_chk_en,
                                    par_chk_en, stp_chk_en, data_valid, frame_err}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ps;
        bit  p, g, pe, se, b2b, tog, prev_b2b, prev_p;

        @(negedge clk);
        chk("reset_outputs", int'({edge_bit_enable, dat_samp_en, deser_en, strt_chk_en,
                                   par_chk_en, stp_chk_en, data_valid, frame_err}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send_frame(8,  0, 0, 0, 0, 0, 0, 8'hA5);   // clean frame, no parity
        send_frame(16, 1, 0, 1, 0, 0, 0, 8'h3C);   // parity error
        send_frame(16, 0, 1, 0, 0, 0, 0, 8'h00);   // start glitch
        send_frame(8,  0, 0, 0, 0, 1, 0, 8'h11);   // back-to-back pair
        send_frame(8,  0, 0, 0, 0, 0, 0, 8'h22);
        send_frame(16, 0, 0, 0, 0, 0, 1, 8'h5A);   // PAR_EN toggled mid-data
        send_frame(16, 1, 0, 0, 0, 0, 1, 8'hC3);
        reset_mid_frame();
        send_frame(32, 1, 0, 0, 1, 0, 0, 8'hF0);   // stop error
        send_frame(12, 0, 0, 0, 0, 0, 0, 8'h96);   // non-standard prescale still completes

        prev_b2b = 0; prev_p = 0;
        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 2))
                0:       ps = 8;
                1:       ps = 16;
                default: ps = 32;
            endcase
            g   = ($urandom_range(0, 5) == 0);
            p   = prev_b2b ? prev_p : 1'($urandom_range(0, 1));
            pe  = 1'($urandom_range(0, 1));
            se  = ($urandom_range(0, 3) == 0);
            b2b = !g && ($urandom_range(0, 2) == 0) && (k != 19);
            tog = 1'($urandom_range(0, 1));
            send_frame(ps, p, g, pe, se, b2b, tog, 8'($urandom));
            prev_b2b = b2b; prev_p = p;
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
